// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM request front-end.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 25;
  localparam int unsigned SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// In-order request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = req_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; only entries below count are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_req_queue.sv
// Request queue in front of the SDRAM controller: buffers requests, issues them
// one at a time over req/ack, and returns read data with a watchdog fallback.
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
  parameter int unsigned DATA_W     = SDRAM_DATA_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  localparam int unsigned WdW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  // Fire when the incremented watchdog would reach RD_TIMEOUT-1.
  localparam logic [WdW-1:0] WdLast = WdW'(RD_TIMEOUT - 2);

  state_e            state_q, state_d;
  entry_t            push_data, head;
  logic              push, pop, full, empty;
  logic [WdW-1:0]    wd_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              err_q;
  logic              timeout;

  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign push_data = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign timeout   = (wd_q == WdLast);

  sdram_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (level),
    .full      (full),
    .empty     (empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StIssue;
      StIssue:  if (mem_ack) state_d = mem_we_q ? StIdle : StWaitRd;
      StWaitRd: if (mem_rvalid || timeout) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs; mem_req decodes the state flop so reset drops it at once.
  always_comb begin
    mem_req = (state_q == StIssue);
    pop     = (state_q == StIssue) && mem_ack;
  end

  // Latch the FIFO head into the controller-facing fields while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (state_q == StIdle && !empty) begin
      mem_we_q    <= head.we;
      mem_addr_q  <= head.addr;
      mem_wdata_q <= head.wdata;
    end
  end

  // Read watchdog: cleared while issuing, counts while waiting for data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       wd_q <= '0;
    else if (state_q == StIssue)   wd_q <= '0;
    else if (state_q == StWaitRd)  wd_q <= wd_q + WdW'(1);
  end

  // Response strobe and data; real data beats a coincident timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (state_q == StWaitRd) begin
        if (mem_rvalid) begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= mem_rdata;
        end else if (timeout) begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          err_q        <= 1'b1;
        end
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign err        = err_q;

endmodule
